// File: rtl/periph_pkg.sv
// Shared definitions for the UART transmitter peripheral: register offsets,
// STATUS bit positions and the serializer state encoding.
package periph_pkg;

   // Register offsets within the 16-byte window (mem_addr[3:0])
   localparam logic [3:0] REG_DATA   = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h4;
   localparam logic [3:0] REG_BAUD   = 4'h8;
   localparam logic [3:0] REG_RSVD   = 4'hC;

   // STATUS register fields
   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_FULL    = 1;
   localparam int unsigned STAT_EMPTY   = 2;
   localparam int unsigned STAT_LVL_LSB = 8;
   localparam int unsigned STAT_LVL_W   = 7;

   // Serializer states; ST_PARITY is only visited in parity-enabled builds
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

endpackage

// File: rtl/periph_sync_fifo.sv
// Synchronous show-ahead FIFO: rdata_c always presents the oldest entry.
// Ports: clk, rst_n (async active-low), push/wdata, pop, rdata_c (comb),
//        full, empty, level (registered occupancy 0..DEPTH).
// DEPTH must be a power of two so the pointers wrap naturally.
module periph_sync_fifo #(
   parameter  int unsigned DEPTH = 8,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned LW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata_c,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push_c;
   logic             do_pop_c;
   logic [LW-1:0]    level_nxt_c;

   assign do_push_c = push && !full;
   assign do_pop_c  = pop && !empty;
   assign rdata_c   = mem[rd_ptr];

   // Occupancy update; simultaneous push and pop leave it unchanged
   always_comb begin
      level_nxt_c = level;
      case ({do_push_c, do_pop_c})
         2'b10:   level_nxt_c = level + LW'(1);
         2'b01:   level_nxt_c = level - LW'(1);
         default: level_nxt_c = level;
      endcase
   end

   // Storage (no reset needed; guarded by the pointers)
   always_ff @(posedge clk) begin
      if (do_push_c) mem[wr_ptr] <= wdata;
   end

   // Pointers and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt_c;
         full  <= (level_nxt_c == LW'(DEPTH));
         empty <= (level_nxt_c == LW'(0));
      end
   end

endmodule

// File: rtl/periph_uart_tx.sv
// Memory-mapped UART transmitter with TX FIFO and programmable bit period.
// Ports: sys_clk, rst_n (async active-low); mem_valid/mem_ready/mem_addr/
//        mem_wdata/mem_wstrb/mem_rdata simple bus (one-cycle ready pulse);
//        uart_tx serial output (idle high).
// Build option: define UART_TX_PARITY_EN to add an even-parity bit.
module periph_uart_tx
   import periph_pkg::*;
#(
   parameter logic [31:0]  BASE_ADDR      = 32'h0300_0000,
   parameter int unsigned  FIFO_DEPTH     = 8,
   parameter logic [15:0]  RESET_BAUD_DIV = 16'd434
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        uart_tx
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic             hit_c;
   logic             is_wr_c;
   logic             data_req_c;
   logic             accept_c;
   logic             push_c;
   logic             pop_c;
   logic [31:0]      status_c;
   logic [31:0]      rdata_c;
   logic [15:0]      baud_div;
   logic [15:0]      div_eff_c;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LVL_W-1:0] fifo_level;
   logic [7:0]       fifo_rdata_c;
   tx_state_e        state;
   logic [15:0]      div_q;
   logic [15:0]      cnt_q;
   logic [7:0]       shreg;
   logic [2:0]       bit_idx;
   logic             bit_end_c;
`ifdef UART_TX_PARITY_EN
   logic             par_q;
`endif
   logic             unused_c;

   assign unused_c = ^{mem_wdata[31:16], BASE_ADDR[3:0]};

   // Bus decode; a DATA push is held off (no ack) while the FIFO is full
   assign hit_c      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign is_wr_c    = |mem_wstrb;
   assign data_req_c = (mem_addr[3:0] == REG_DATA) && mem_wstrb[0];
   assign accept_c   = hit_c && !mem_ready && !(data_req_c && fifo_full);
   assign push_c     = accept_c && data_req_c;

   always_comb begin
      status_c = '0;
      status_c[STAT_BUSY]  = (state != ST_IDLE);
      status_c[STAT_FULL]  = fifo_full;
      status_c[STAT_EMPTY] = fifo_empty;
      status_c[STAT_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(fifo_level);
   end

   always_comb begin
      rdata_c = '0;
      if (!is_wr_c) begin
         case (mem_addr[3:0])
            REG_STATUS: rdata_c = status_c;
            REG_BAUD:   rdata_c = {16'h0000, baud_div};
            REG_RSVD:   rdata_c = '0;
            default:    rdata_c = '0;
         endcase
      end
   end

   // Bus response and BAUD_DIV register
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         baud_div  <= RESET_BAUD_DIV;
      end else begin
         mem_ready <= accept_c;
         mem_rdata <= accept_c ? rdata_c : 32'h0;
         if (accept_c && (mem_addr[3:0] == REG_BAUD)) begin
            if (mem_wstrb[0]) baud_div[7:0]  <= mem_wdata[7:0];
            if (mem_wstrb[1]) baud_div[15:8] <= mem_wdata[15:8];
         end
      end
   end

   periph_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (sys_clk),
      .rst_n   (rst_n),
      .push    (push_c),
      .wdata   (mem_wdata[7:0]),
      .pop     (pop_c),
      .rdata_c (fifo_rdata_c),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // A divisor of 0 behaves as 1; latched only when a frame starts
   assign div_eff_c = (baud_div == 16'd0) ? 16'd1 : baud_div;
   assign bit_end_c = (cnt_q == div_q - 16'd1);
   // Pop from IDLE, or at the end of STOP so frames run back to back
   assign pop_c     = !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && bit_end_c));

   // Serializer
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         uart_tx <= 1'b1;
         div_q   <= 16'd1;
         cnt_q   <= '0;
         shreg   <= '0;
         bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else if (pop_c) begin
         state   <= ST_START;
         uart_tx <= 1'b0;
         div_q   <= div_eff_c;
         cnt_q   <= '0;
         shreg   <= fifo_rdata_c;
`ifdef UART_TX_PARITY_EN
         par_q   <= ^fifo_rdata_c;
`endif
      end else if (state != ST_IDLE) begin
         if (!bit_end_c) begin
            cnt_q <= cnt_q + 16'd1;
         end else begin
            cnt_q <= '0;
            case (state)
               ST_START: begin
                  state   <= ST_DATA;
                  uart_tx <= shreg[0];
                  bit_idx <= '0;
               end
               ST_DATA: begin
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state   <= ST_PARITY;
                     uart_tx <= par_q;
`else
                     state   <= ST_STOP;
                     uart_tx <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     uart_tx <= shreg[1];
                  end
               end
`ifdef UART_TX_PARITY_EN
               ST_PARITY: begin
                  state   <= ST_STOP;
                  uart_tx <= 1'b1;
               end
`endif
               default: begin
                  // End of STOP with nothing queued
                  state   <= ST_IDLE;
                  uart_tx <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_periph_uart_tx.sv
// Self-checking bench for periph_uart_tx: register access vectors followed
// by directed frame, back-to-back, divisor, FIFO-full and reset sequences.
module tb_periph_uart_tx;

   localparam logic [31:0] BASE = 32'h0300_0000;

   logic        sys_clk;
   logic        rst_n;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        uart_tx;

   int n_checks = 0;
   int n_fail   = 0;

   periph_uart_tx #(
      .BASE_ADDR      (BASE),
      .FIFO_DEPTH     (8),
      .RESET_BAUD_DIV (16'd434)
   ) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .uart_tx   (uart_tx)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      bit          exp_ready;
      logic [31:0] exp_rdata;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One bus access; gives up after 'limit' cycles without ready
   task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int limit,
                           output bit got, output int lat, output logic [31:0] rd);
      @(posedge sys_clk); #1;
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = strb;
      got = 1'b0;
      lat = 0;
      rd  = '0;
      while (!got && lat < limit) begin
         @(posedge sys_clk); #1;
         lat++;
         if (mem_ready === 1'b1) begin
            got = 1'b1;
            rd  = mem_rdata;
         end
      end
      mem_valid = 1'b0;
      mem_wstrb = '0;
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] strb,
                     input string name);
      bit got; int lat; logic [31:0] rd;
      bus_xfer(BASE + 32'(off), d, strb, 20, got, lat, rd);
      chk({name, "_ack"}, 32'(got), 32'd1);
   endtask

   task automatic rd_chk(input logic [3:0] off, input logic [31:0] exp, input string name);
      bit got; int lat; logic [31:0] rd;
      bus_xfer(BASE + 32'(off), 32'h0, 4'h0, 20, got, lat, rd);
      chk({name, "_ack"}, 32'(got), 32'd1);
      chk(name, rd, exp);
   endtask

   // Waits up to max_wait cycles for a start bit, then compares every cycle
   task automatic check_frame(input logic [7:0] d, input int div, input int max_wait,
                              input string name);
      logic [10:0] bits;
      int nb, w, errs;
      bit found;
`ifdef UART_TX_PARITY_EN
      nb = 11;
      bits = {1'b1, ^d, d, 1'b0};
`else
      nb = 10;
      bits = {1'b0, 1'b1, d, 1'b0};
`endif
      w = 0;
      found = 1'b0;
      while (!found && w < max_wait) begin
         @(posedge sys_clk); #1;
         w++;
         if (uart_tx === 1'b0) found = 1'b1;
      end
      chk({name, "_start"}, 32'(found), 32'd1);
      if (found) begin
         errs = 0;
         for (int c = 1; c < nb * div; c++) begin
            @(posedge sys_clk); #1;
            if (uart_tx !== bits[c / div]) errs++;
         end
         chk({name, "_bits"}, 32'(errs), 32'd0);
      end
   endtask

   initial begin
      bit got; int lat; logic [31:0] rd; int lows; bit found;

      rst_n     = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("rst_ready", 32'(mem_ready), 32'd0);
      chk("rst_rdata", mem_rdata, 32'h0);
      #1 rst_n = 1'b1;

      // Register access vectors
      vecs.push_back('{32'h4,         32'h0,         4'h0, 1'b1, 32'h0000_0004, "status_rst"});
      vecs.push_back('{32'h8,         32'h0,         4'h0, 1'b1, 32'h0000_01B2, "baud_rst"});
      vecs.push_back('{32'h8,         32'h0000_1234, 4'h1, 1'b1, 32'h0,         "baud_wr_b0"});
      vecs.push_back('{32'h8,         32'h0,         4'h0, 1'b1, 32'h0000_0134, "baud_rd_b0"});
      vecs.push_back('{32'h8,         32'hABCD_5678, 4'hE, 1'b1, 32'h0,         "baud_wr_b1"});
      vecs.push_back('{32'h8,         32'h0,         4'h0, 1'b1, 32'h0000_5634, "baud_rd_b1"});
      vecs.push_back('{32'hC,         32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,         "rsvd_wr"});
      vecs.push_back('{32'hC,         32'h0,         4'h0, 1'b1, 32'h0,         "rsvd_rd"});
      vecs.push_back('{32'h0,         32'h0,         4'h0, 1'b1, 32'h0,         "data_rd"});
      vecs.push_back('{32'h0,         32'h0000_00FF, 4'h2, 1'b1, 32'h0,         "data_wr_nob0"});
      vecs.push_back('{32'h4,         32'h0,         4'h0, 1'b1, 32'h0000_0004, "status_nopush"});
      vecs.push_back('{32'h10,        32'h0,         4'h0, 1'b0, 32'h0,         "oow_rd"});
      vecs.push_back('{32'h10,        32'h0000_0055, 4'h1, 1'b0, 32'h0,         "oow_wr"});
      vecs.push_back('{32'h1000_0004, 32'h0,         4'h0, 1'b0, 32'h0,         "oow_hi_rd"});
      vecs.push_back('{32'h4,         32'h0,         4'h0, 1'b1, 32'h0000_0004, "status_after_oow"});
      vecs.push_back('{32'h8,         32'h0000_0004, 4'h3, 1'b1, 32'h0,         "baud_wr4"});
      vecs.push_back('{32'h8,         32'h0,         4'h0, 1'b1, 32'h0000_0004, "baud_rd4"});

      foreach (vecs[i]) begin
         bus_xfer(BASE + vecs[i].addr, vecs[i].wdata, vecs[i].strb, 20, got, lat, rd);
         chk({vecs[i].name, "_ready"}, 32'(got), 32'(vecs[i].exp_ready));
         if (vecs[i].exp_ready) begin
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            @(posedge sys_clk); #1;
            chk({vecs[i].name, "_pulse"}, 32'(mem_ready), 32'd0);
         end
      end

      // Basic frame at BAUD_DIV=4, then idle STATUS
      wr(4'h0, 32'h0000_00A5, 4'h1, "data_a5");
      check_frame(8'hA5, 4, 4, "frame_a5");
      rd_chk(4'h4, 32'h0000_0004, "status_idle");

      // Frame whose parity bit is 1 in parity builds
      wr(4'h0, 32'h0000_0007, 4'h1, "data_07");
      check_frame(8'h07, 4, 4, "frame_07");

      // Back-to-back frames; divisor change mid-frame applies to the next one
      wr(4'h0, 32'h0000_005A, 4'h1, "data_5a");
      fork
         begin
            check_frame(8'h5A, 4, 4, "frame_5a_div4");
            check_frame(8'hC3, 8, 1, "frame_c3_div8");
         end
         begin
            wr(4'h0, 32'h0000_00C3, 4'h1, "data_c3");
            repeat (8) @(posedge sys_clk);
            wr(4'h8, 32'h0000_0008, 4'h3, "baud_wr8_mid");
         end
      join

      // Divisor 0 gives 1-cycle bits
      wr(4'h8, 32'h0000_0000, 4'h3, "baud_wr0");
      rd_chk(4'h8, 32'h0000_0000, "baud_rd0");
      wr(4'h0, 32'h0000_0096, 4'h1, "data_96");
      check_frame(8'h96, 1, 4, "frame_96_div1");

      // FIFO full stall: one frame in flight, then nine more writes
      repeat (4) @(posedge sys_clk);
      wr(4'h8, 32'h0000_0010, 4'h3, "baud_wr16");
      wr(4'h0, 32'h0000_0011, 4'h1, "data_11");
      for (int k = 0; k < 8; k++) begin
         bus_xfer(BASE, 32'(8'h20 + k), 4'h1, 20, got, lat, rd);
         chk($sformatf("fill_%0d_lat", k), 32'(lat), 32'd1);
      end
      rd_chk(4'h4, 32'h0000_0803, "status_full");
      bus_xfer(BASE, 32'h0000_0028, 4'h1, 400, got, lat, rd);
      chk("stall_ready", 32'(got), 32'd1);
      chk("stall_delayed", 32'(lat > 20), 32'd1);
      chk("stall_after_pop", 32'(uart_tx), 32'd0);
      rd_chk(4'h4, 32'h0000_0803, "status_full_again");

      @(posedge sys_clk); #2 rst_n = 1'b0;
      repeat (2) @(posedge sys_clk);
      #2 rst_n = 1'b1;
      rd_chk(4'h4, 32'h0000_0004, "status_after_rst");

      // Reset during DATA bit 3 of 0xA5 (bit 3 is 0)
      wr(4'h8, 32'h0000_0004, 4'h3, "baud_wr4_b");
      wr(4'h0, 32'h0000_00A5, 4'h1, "data_a5_b");
      found = 1'b0;
      for (int w = 0; w < 8 && !found; w++) begin
         @(posedge sys_clk); #1;
         if (uart_tx === 1'b0) found = 1'b1;
      end
      chk("rstmid_start", 32'(found), 32'd1);
      repeat (17) @(posedge sys_clk);
      #1;
      chk("rstmid_bit3", 32'(uart_tx), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_async_tx", 32'(uart_tx), 32'd1);
      repeat (3) @(posedge sys_clk);
      #2 rst_n = 1'b1;
      lows = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge sys_clk); #1;
         if (uart_tx !== 1'b1) lows++;
      end
      chk("rstmid_line_idle", 32'(lows), 32'd0);
      rd_chk(4'h4, 32'h0000_0004, "rstmid_status");
      rd_chk(4'h8, 32'h0000_01B2, "rstmid_baud");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
